// File: rtl/secded_pkg.sv
// Shared widths, bit-position tables and result classes for the
// Hamming(12,8)+overall-parity SECDED stream decoder.
package secded_pkg;

   localparam int CW_W   = 13;
   localparam int HAM_W  = 12;
   localparam int DATA_W = 8;
   localparam int SYN_W  = 4;

   // Codeword index i carries Hamming position i+1.
   localparam int PARITY_IDX [SYN_W]  = '{0, 1, 3, 7};
   localparam int DATA_IDX   [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

   typedef enum logic [1:0] {
      CLS_CLEAN = 2'd0,
      CLS_CE    = 2'd1,
      CLS_UE    = 2'd2
   } secded_class_e;

   function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W; i++) begin
         d[i] = cw[DATA_IDX[i]];
      end
      return d;
   endfunction

endpackage

// File: rtl/secded_syndrome_calc.sv
// Combinational Hamming syndrome and overall-parity check of one codeword.
module secded_syndrome_calc
   import secded_pkg::*;
(
   input  logic [CW_W-1:0]  codeword_i,
   output logic [SYN_W-1:0] syndrome_o,
   output logic             overall_o
);

   // Parity bit k sits at position 2^k, so it covers positions with bit k set.
   always_comb begin
      syndrome_o = '0;
      for (int k = 0; k < SYN_W; k++) begin
         for (int j = 0; j < HAM_W; j++) begin
            if (((j + 1) & (PARITY_IDX[k] + 1)) != 0) begin
               syndrome_o[k] = syndrome_o[k] ^ codeword_i[j];
            end
         end
      end
   end

   assign overall_o = ^codeword_i;

endmodule

// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage SECDED stream decoder with valid/ready flow control,
// saturating CE/UE counters and a sticky first-UE capture.
module hamming_secded_stream_decoder
   import secded_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CW_W-1:0]      in_codeword,
   input  logic [7:0]           in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [7:0]           out_tag,
   output logic [SYN_W-1:0]     out_syndrome,
   output logic                 out_ce,
   output logic                 out_ue,
   output logic [CNT_WIDTH-1:0] ce_count,
   output logic [CNT_WIDTH-1:0] ue_count,
   input  logic                 clr_counts,
   output logic                 err_irq,
   input  logic                 irq_clear,
   output logic [7:0]           first_ue_tag,
   output logic                 first_ue_valid
);

   logic [SYN_W-1:0] in_syn;
   logic             in_ovr;

   secded_syndrome_calc u_syn (
      .codeword_i (in_codeword),
      .syndrome_o (in_syn),
      .overall_o  (in_ovr)
   );

   logic                 s1_valid_q, s2_valid_q;
   logic [CW_W-1:0]      s1_cw_q;
   logic [7:0]           s1_tag_q, s2_tag_q;
   logic [SYN_W-1:0]     s1_syn_q, s2_syn_q;
   logic                 s1_ovr_q, s2_ce_q, s2_ue_q;
   logic [DATA_W-1:0]    s2_data_q, s2_data_d;
   logic [CNT_WIDTH-1:0] ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;
   logic                 irq_q, irq_d, fv_q, fv_d;
   logic [7:0]           ftag_q, ftag_d;
   logic                 en1, en2, out_hs;
   secded_class_e        s2_cls_d;
   logic [CW_W-1:0]      fix_cw;

   assign en2      = !s2_valid_q || out_ready;
   assign en1      = !s1_valid_q || en2;
   assign in_ready = en1;
   assign out_hs   = s2_valid_q && out_ready;

   // Only a single error inside the Hamming part is flipped; bit 12 alone leaves data as is.
   always_comb begin
      s2_cls_d = CLS_UE;
      fix_cw   = s1_cw_q;
      if (!s1_ovr_q) begin
         if (s1_syn_q == '0) s2_cls_d = CLS_CLEAN;
      end else if (s1_syn_q == '0) begin
         s2_cls_d = CLS_CE;
      end else if (s1_syn_q <= 4'd12) begin
         s2_cls_d = CLS_CE;
         fix_cw   = s1_cw_q ^ (CW_W'(1) << (s1_syn_q - 4'd1));
      end
   end

   assign s2_data_d = extract_data(fix_cw);

   always_comb begin
      ce_cnt_d = ce_cnt_q;
      ue_cnt_d = ue_cnt_q;
      if (clr_counts) begin
         ce_cnt_d = '0;
         ue_cnt_d = '0;
      end else if (out_hs) begin
         if (s2_ce_q && ce_cnt_q != '1) ce_cnt_d = ce_cnt_q + CNT_WIDTH'(1);
         if (s2_ue_q && ue_cnt_q != '1) ue_cnt_d = ue_cnt_q + CNT_WIDTH'(1);
      end
   end

   // A UE handshake beats a same-cycle irq_clear, and re-arms the capture.
   always_comb begin
      irq_d  = irq_q;
      fv_d   = fv_q;
      ftag_d = ftag_q;
      if (out_hs && s2_ue_q) begin
         irq_d = 1'b1;
         fv_d  = 1'b1;
         if (!fv_q || irq_clear) ftag_d = s2_tag_q;
      end else if (irq_clear) begin
         irq_d = 1'b0;
         fv_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_cw_q    <= '0;
         s1_tag_q   <= '0;
         s1_syn_q   <= '0;
         s1_ovr_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
         s2_syn_q   <= '0;
         s2_ce_q    <= 1'b0;
         s2_ue_q    <= 1'b0;
         ce_cnt_q   <= '0;
         ue_cnt_q   <= '0;
         irq_q      <= 1'b0;
         fv_q       <= 1'b0;
         ftag_q     <= '0;
      end else begin
         if (en1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_cw_q  <= in_codeword;
               s1_tag_q <= in_tag;
               s1_syn_q <= in_syn;
               s1_ovr_q <= in_ovr;
            end
         end
         if (en2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_data_q <= s2_data_d;
               s2_tag_q  <= s1_tag_q;
               s2_syn_q  <= s1_syn_q;
               s2_ce_q   <= (s2_cls_d == CLS_CE);
               s2_ue_q   <= (s2_cls_d == CLS_UE);
            end
         end
         ce_cnt_q <= ce_cnt_d;
         ue_cnt_q <= ue_cnt_d;
         irq_q    <= irq_d;
         fv_q     <= fv_d;
         ftag_q   <= ftag_d;
      end
   end

   assign out_valid      = s2_valid_q;
   assign out_data       = s2_data_q;
   assign out_tag        = s2_tag_q;
   assign out_syndrome   = s2_syn_q;
   assign out_ce         = s2_ce_q;
   assign out_ue         = s2_ue_q;
   assign ce_count       = ce_cnt_q;
   assign ue_count       = ue_cnt_q;
   assign err_irq        = irq_q;
   assign first_ue_valid = fv_q;
   assign first_ue_tag   = ftag_q;

endmodule

// File: doc/hamming_secded_stream_decoder.md
HAMMING_SECDED_STREAM_DECODER -- requirements
Module: hamming_secded_stream_decoder

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the error counters.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  codeword present; in_ready  output  1  decoder accepts.
REQ-005 in_codeword  input  13  SECDED codeword: [11:0] Hamming(12,8), [12] overall parity.
REQ-006 in_tag  input  8  opaque address/tag, carried alongside its codeword.
REQ-007 out_valid  output  1  result present; out_ready  input  1  sink accepts.
REQ-008 out_data  output  8; out_tag  output  8; out_syndrome  output  4; out_ce  output  1 (corrected); out_ue  output  1 (uncorrectable).
REQ-009 ce_count, ue_count  output  CNT_WIDTH  saturating error counters; clr_counts  input  1  synchronous counter clear.
REQ-010 err_irq  output  1  sticky UE flag; irq_clear  input  1; first_ue_tag  output  8; first_ue_valid  output  1.

Function
REQ-011 Codeword index i SHALL carry Hamming position i+1: parity at indices 0,1,3,7; data bits d0..d7 at indices 2,4,5,6,8,9,10,11.
REQ-012 Syndrome bit k SHALL be the XOR of in_codeword[j] over j in 0..11 with ((j+1)>>k)&1; overall check = XOR of all 13 bits.
REQ-013 Classification: syndrome 0 with overall 0 -> clean. Syndrome 1..12 with overall 1 -> CE, flip bit syndrome-1. Syndrome 0 with overall 1 -> CE (bit 12 only, data unchanged). Syndrome nonzero with overall 0 -> UE. Syndrome 13..15 with overall 1 -> UE.
REQ-014 On UE, out_data SHALL be the uncorrected extracted data; out_ce=0, out_ue=1.
REQ-015 Two-stage pipeline: S1 registers the codeword, tag, syndrome and overall check; S2 registers data, tag, syndrome and flags. Latency is exactly 2 cycles from the in handshake to out_valid when unstalled.
REQ-016 en2 = !s2_valid || out_ready; en1 = !s1_valid || en2; in_ready = en1 (combinational from out_ready).
REQ-017 Full throughput: one codeword per cycle while out_ready=1; no loss or duplication under any backpressure pattern; order preserved.
REQ-018 Output fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 Counters SHALL increment on the output handshake (out_valid&&out_ready) with out_ce/out_ue, and saturate at all-ones.
REQ-020 clr_counts SHALL zero both counters; it wins over a same-cycle increment.
REQ-021 err_irq SHALL set on a UE output handshake. If first_ue_valid=0 at that handshake, out_tag is captured into first_ue_tag and first_ue_valid is set.
REQ-022 irq_clear SHALL clear err_irq and first_ue_valid. A same-cycle UE handshake wins: flag set, tag captured.

Reset
REQ-023 Asserting rst_n low SHALL immediately clear s1_valid, s2_valid, out_valid, counters, err_irq and first_ue_valid, and zero all data/tag/flag registers. in_ready=1 after reset.
REQ-024 Reset mid-stream SHALL discard in-flight codewords with no counter effect.

Structure
REQ-025 Shared package secded_pkg: codeword width 13, data width 8, syndrome width 4, parity/data index tables, and the result-class enum CLEAN/CE/UE.
REQ-026 One sub-module, secded_syndrome_calc (combinational syndrome and overall check). The pipeline, counters and IRQ logic stay in the top module.

Verification
REQ-027 Clean: in_codeword=13'h0A27, tag 8'h10 -> 2 cycles later out_data=8'hA5, out_syndrome=0, ce=ue=0.
REQ-028 Single error: 13'h0A07 -> out_data=8'hA5, out_syndrome=6, out_ce=1, ce_count+1. Also 13'h1A27 -> out_data=8'hA5, out_syndrome=0, out_ce=1.
REQ-029 Double error: 13'h0A24, tag 8'h3C -> out_syndrome=3, out_ue=1, err_irq=1, first_ue_tag=8'h3C. A second UE with tag 8'h55 leaves first_ue_tag=8'h3C.
REQ-030 Backpressure: 20 back-to-back codewords with random out_ready -> all 20 outputs in order, none lost; in_ready deasserts only while both stages are full and out_ready=0.
REQ-031 Saturation/precedence: force ce_count to all-ones, then a CE -> stays all-ones. clr_counts concurrent with a CE -> 0. irq_clear concurrent with a UE handshake -> err_irq=1.
REQ-032 Reset with both stages full -> out_valid=0 immediately, counters 0, and the next codeword decodes normally.
